// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours (imem, execute redirect, decode).
// misalign_trap exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_stage_if;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  modport master (
    input  halt, redirect_valid, redirect_target, id_ready, imem_rd,
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    , output misalign_trap
`endif
  );

  modport slave (
    output halt, redirect_valid, redirect_target, id_ready, imem_rd,
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    , input misalign_trap
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the combinational imem and fills IF/ID.
// Optional FETCH_MISALIGN_TRAP_EN adds a RUN/TRAP FSM for misaligned redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           i_clk,
  input logic           i_reset,
  fetch_stage_if.master bus
);

  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;

  logic        w_load;
  logic        w_hold_fetch;
  logic [31:0] w_target;

  assign w_load = !r_if_valid || bus.id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  logic [0:0] r_state;
  logic       r_misalign_trap;
  logic       w_misaligned;

  assign w_target     = bus.redirect_target;
  assign w_misaligned = (bus.redirect_target[1:0] != 2'b00);
  assign w_hold_fetch = (r_state == ST_TRAP);

  // Only a redirect moves between RUN and TRAP; the trap flag mirrors the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= ST_RUN;
      r_misalign_trap <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_state         <= w_misaligned ? ST_TRAP : ST_RUN;
      r_misalign_trap <= w_misaligned;
    end
  end

  assign bus.misalign_trap = r_misalign_trap;
`else
  logic w_unused_tgt_lsbs;

  assign w_unused_tgt_lsbs = ^bus.redirect_target[1:0];
  assign w_target          = {bus.redirect_target[31:2], 2'b00};
  assign w_hold_fetch      = 1'b0;
`endif

  // PC and IF/ID register: reset > redirect > trap hold > halt > load > stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= NOP_INSTR;
      r_if_pc       <= 32'h0000_0000;
      r_if_pc_plus4 <= 32'h0000_0004;
    end else if (bus.redirect_valid) begin
      r_pc       <= w_target;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (w_hold_fetch) begin
      r_pc <= r_pc;
    end else if (bus.halt && w_load) begin
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_if_instr    <= bus.imem_rd;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= r_pc + 32'd4;
      r_if_valid    <= 1'b1;
      r_pc          <= r_pc + 32'd4;
    end
  end

  assign bus.imem_addr   = {2'b00, r_pc[31:2]};
  assign bus.if_valid    = r_if_valid;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by random traffic, all checked
// against a transaction-level reference model; define FETCH_MISALIGN_TRAP_EN to match the DUT.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: next fetch address, IF/ID slot contents, trap flag.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_trap;

  function automatic logic [31:0] mem_word(input logic [31:0] word_idx);
    return 32'h1000_0000 + word_idx;
  endfunction

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  assign bus.imem_rd = mem_word(bus.imem_addr);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the architectural rules of one clock edge to the model.
  task automatic model_edge();
    logic can_take;
    can_take = !m_valid || bus.id_ready;
    if (reset) begin
      m_pc = 32'h0000_0000; m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0000_0000; m_trap = 1'b0;
    end else if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc   = bus.redirect_target;
      m_trap = (bus.redirect_target % 4) != 0;
`else
      m_pc   = bus.redirect_target & 32'hFFFF_FFFC;
      m_trap = 1'b0;
`endif
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (m_trap) begin
      m_valid = 1'b0;
    end else if (bus.halt && can_take) begin
      m_valid = 1'b0;
    end else if (can_take) begin
      m_instr = mem_word(m_pc / 4);
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic check_model();
    chk("imem_addr",   bus.imem_addr,           m_pc / 4);
    chk("if_valid",    {31'd0, bus.if_valid},   {31'd0, m_valid});
    chk("if_instr",    bus.if_instr,            m_instr);
    chk("if_pc",       bus.if_pc,               m_ifpc);
    chk("if_pc_plus4", bus.if_pc_plus4,         m_ifpc + 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_trap", {31'd0, bus.misalign_trap}, {31'd0, m_trap});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_in(input logic rst, input logic hlt, input logic rv,
                        input logic [31:0] tgt, input logic rdy);
    reset               = rst;
    bus.halt            = hlt;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.id_ready        = rdy;
  endtask

  initial begin
    logic [31:0] tgt;
    int          pick;

    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, NOP);
    chk("rst_pc4",   bus.if_pc_plus4, 32'd4);

    // Reset release with decode always ready.
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("first_instr", bus.if_instr, 32'h1000_0000);
    chk("first_addr",  bus.imem_addr, 32'd1);
    step();
    step();
    chk("third_pc", bus.if_pc, 32'h8);

    // Back-pressure while if_pc = 8.
    bus.id_ready = 1'b0;
    repeat (3) step();
    chk("stall_pc",   bus.if_pc, 32'h8);
    chk("stall_addr", bus.imem_addr, 32'd3);
    bus.id_ready = 1'b1;
    step();
    chk("resume_pc", bus.if_pc, 32'hC);

    // Redirect to 0x40 during a stall.
    set_in(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    step();
    chk("redir_addr", bus.imem_addr, 32'h10);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("redir_pc",  bus.if_pc, 32'h40);
    chk("redir_pc4", bus.if_pc_plus4, 32'h44);

    // Halt for two cycles with decode ready.
    bus.halt = 1'b1;
    repeat (2) step();
    chk("halt_valid", {31'd0, bus.if_valid}, 32'd0);
    bus.halt = 1'b0;
    step();
    chk("halt_resume_pc", bus.if_pc, 32'h44);

    // PC wrap at the top of the address space.
    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("wrap_pc",  bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.if_pc_plus4, 32'h0);
    step();
    chk("wrap_next", bus.if_pc, 32'h0);

    // Misaligned redirect.
    set_in(1'b0, 1'b0, 1'b1, 32'h42, 1'b1);
    step();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (5) step();
    chk("trap_flag",  {31'd0, bus.misalign_trap}, 32'd1);
    chk("trap_valid", {31'd0, bus.if_valid}, 32'd0);
    set_in(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("trap_exit_pc", bus.if_pc, 32'h80);
`else
    step();
    chk("misalign_forced_pc", bus.if_pc, 32'h40);
`endif

    // Reset wins over simultaneous redirect, halt and stall.
    step();
    set_in(1'b1, 1'b1, 1'b1, 32'h123, 1'b0);
    step();
    chk("rst_prio_addr", bus.imem_addr, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        2:       tgt = {$urandom_range(0, 255), 2'b00};
        default: tgt = 32'h40 + $urandom_range(0, 3);
      endcase
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core; sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory's word address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles decode back-pressure, a fetch-halt request, and branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- NOP_INSTR, 32'h0000_0013, value held in if_instr at reset and after flush (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- halt  input  1  when high, no new fetch issues; PC held
- redirect_valid  input  1  branch/jump taken in execute
- redirect_target  input  32  byte address of redirect destination
- id_ready  input  1  decode accepts the IF/ID entry this cycle
- imem_addr  output  32  word index to instruction memory, {2'b00, pc_q[31:2]}
- imem_rd  input  32  instruction word from memory (combinational, same cycle)
- if_valid  output  1  IF/ID entry holds a valid instruction
- if_instr  output  32  fetched instruction
- if_pc  output  32  byte address of if_instr
- if_pc_plus4  output  32  if_pc + 4
- misalign_trap  output  1  present only with FETCH_MISALIGN_TRAP_EN

Behaviour:
- Reset (synchronous, highest priority, wins over every other input, including mid-stall or mid-redirect):
  - pc_q = RESET_PC
  - if_valid = 0
  - if_instr = NOP_INSTR
  - if_pc = 0
  - if_pc_plus4 = 4
  - misalign_trap = 0
- imem_addr is purely combinational from pc_q; no registered address.
- Load condition: load = !if_valid || id_ready (IF/ID slot empty or being consumed).
- Per-cycle priority, highest first:
  1. reset
  2. redirect_valid:
     - pc_q <= {redirect_target[31:2], 2'b00}
     - if_valid <= 0; if_instr <= NOP_INSTR (flush)
     - Applies regardless of id_ready or halt.
     - The instruction being fetched this cycle is discarded.
  3. halt with load:
     - if_valid <= 0
     - pc_q held
     - No memory sample taken.
  4. load:
     - if_instr <= imem_rd; if_pc <= pc_q; if_pc_plus4 <= pc_q + 4
     - if_valid <= 1
     - pc_q <= pc_q + 4
  5. otherwise (if_valid && !id_ready): stall; pc_q and all IF/ID outputs held bit-exact.
- Latency:
  - The instruction at address P appears on if_* exactly one cycle after pc_q == P with load true.
  - Sustained throughput is one instruction per cycle when id_ready is high.
- Arithmetic:
  - All PC math is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
  - No address range check; memory depth is the memory's concern.
- Simultaneous events:
  - redirect + stall: redirect wins, entry flushed.
  - redirect + halt: redirect wins, PC updated, nothing loaded.
  - halt drop: fetch resumes at the held pc_q next edge.
- States:
  - RUN only without the macro.
  - RUN/TRAP with the macro (see below).

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN
- Without the macro:
  - redirect_target[1:0] is silently forced to 00.
  - No misalign_trap port; no trap state.
- With the macro:
  - A redirect whose target[1:0] != 00 moves the FSM RUN->TRAP.
  - misalign_trap <= 1 (sticky); pc_q <= target unmodified; if_valid <= 0.
  - In TRAP: no loads; pc_q held.
  - An aligned redirect returns TRAP->RUN and clears misalign_trap next edge.
  - A misaligned redirect while in TRAP stays in TRAP and updates pc_q.
  - Reset returns to RUN.

Test Plan:
- Reset release, id_ready=1, memory word k = 32'h1000_0000+k:
  - imem_addr 0,1,2,3 on consecutive cycles.
  - if_valid rises one cycle after reset drops.
  - if_pc 0,4,8; if_instr 0x10000000, 0x10000001, ...
- Back-pressure: id_ready=0 for 3 cycles while if_pc=8:
  - if_* held at pc 8; pc_q stays 12.
  - On id_ready=1, next entry is pc 12 with no skip or duplicate.
- Redirect to 0x40 during a stall:
  - if_valid=0 next cycle; imem_addr=0x10.
  - Following cycle if_pc=0x40, if_pc_plus4=0x44.
- halt=1 for 2 cycles with id_ready=1:
  - if_valid=0 both cycles; pc_q constant.
  - On release, fetch continues from the held PC.
- Wrap: redirect to 0xFFFF_FFFC:
  - if_pc=0xFFFF_FFFC, if_pc_plus4=0.
  - Next if_pc=0.
- Misalign, macro on: redirect to 0x42:
  - misalign_trap=1; if_valid stays 0 for 5 cycles.
  - Redirect to 0x80 clears the trap; if_pc=0x80 two cycles later.
- Misalign, macro off: redirect to 0x42 -> fetch proceeds at if_pc=0x40.
